// File: rtl/inv_key_expand.sv
// Backward AES-128 key scheduler: emits round keys 10 down to 0, one per handshake.
// Optional key cache enabled with the INV_KEY_CACHE_EN macro.

// Inverse round constant: round_num 0 -> rcon(10), round_num 9 -> rcon(1).
module inv_rcon (
    input  logic [3:0]  round_num,
    output logic [31:0] after_inv_rcon
);
    // Reversed rcon table lookup
    always_comb begin
        after_inv_rcon = 32'h0;
        case (round_num)
            4'd0:    after_inv_rcon = 32'h3600_0000;
            4'd1:    after_inv_rcon = 32'h1b00_0000;
            4'd2:    after_inv_rcon = 32'h8000_0000;
            4'd3:    after_inv_rcon = 32'h4000_0000;
            4'd4:    after_inv_rcon = 32'h2000_0000;
            4'd5:    after_inv_rcon = 32'h1000_0000;
            4'd6:    after_inv_rcon = 32'h0800_0000;
            4'd7:    after_inv_rcon = 32'h0400_0000;
            4'd8:    after_inv_rcon = 32'h0200_0000;
            4'd9:    after_inv_rcon = 32'h0100_0000;
            default: after_inv_rcon = 32'h0;
        endcase
    end
endmodule

module inv_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] last_key_i,
    output logic [127:0] key_out_o,
    output logic [3:0]   key_round_o,
    output logic         key_valid_o,
    input  logic         key_ready_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         cache_hit_o
);
    localparam int unsigned NR = 10;
    localparam int unsigned KW = 128;
    localparam int unsigned RW = 4;

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] key_q, key_d;
    logic [RW-1:0] round_q, round_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Forward S-box: inverse followed by affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [31:0]   w0, w1, w2, w3, p0, p1, p2, p3, rot, rcon;
    logic [RW-1:0] round_num;
    logic [KW-1:0] prev_key;

    assign round_num = RW'(RW'(NR) - round_q);

    inv_rcon u_inv_rcon (
        .round_num      (round_num),
        .after_inv_rcon (rcon)
    );

    // Inverse key recurrence on the current key
    always_comb begin
        {w0, w1, w2, w3} = key_q;
        p3  = w3 ^ w2;
        p2  = w2 ^ w1;
        p1  = w1 ^ w0;
        rot = {p3[23:0], p3[31:24]};
        p0  = w0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ rcon;
        prev_key = {p0, p1, p2, p3};
    end

`ifdef INV_KEY_CACHE_EN
    logic [KW-1:0] mem_q [0:NR];
    logic [KW-1:0] tag_q, tag_d;
    logic          cvalid_q, cvalid_d;
    logic          hit_q, hit_d;
    logic [KW-1:0] cache_rd;

    assign cache_rd    = mem_q[RW'(round_q - RW'(1))];
    assign cache_hit_o = hit_q;

    // Record every key shown during a computed run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(NR); i++) mem_q[i] <= '0;
        end else if (state_q == EMIT && !hit_q && round_q <= RW'(NR)) begin
            mem_q[round_q] <= key_q;
        end
    end

    // Cache tag and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            cvalid_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            cvalid_q <= cvalid_d;
            hit_q    <= hit_d;
        end
    end
`else
    assign cache_hit_o = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef INV_KEY_CACHE_EN
        tag_d    = tag_q;
        cvalid_d = cvalid_q;
        hit_d    = hit_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = EMIT;
                    key_d   = last_key_i;
                    round_d = RW'(NR);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef INV_KEY_CACHE_EN
                    hit_d = cvalid_q && (last_key_i == tag_q);
                    if (!(cvalid_q && (last_key_i == tag_q))) begin
                        tag_d    = last_key_i;
                        cvalid_d = 1'b0;
                    end
`endif
                end
            end
            EMIT: begin
                if (key_ready_i) begin
                    if (round_q != '0) begin
                        round_d = RW'(round_q - RW'(1));
`ifdef INV_KEY_CACHE_EN
                        key_d = hit_q ? cache_rd : prev_key;
`else
                        key_d = prev_key;
`endif
                    end else begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
`ifdef INV_KEY_CACHE_EN
                        cvalid_d = 1'b1;
`endif
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
`ifdef INV_KEY_CACHE_EN
                hit_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_out_o   = key_q;
    assign key_round_o = round_q;
    assign key_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
endmodule
